// File: rtl/hamming_sec_ded_decoder.sv
// Two-stage pipelined SEC-DED decoder for {d[10:0], p0, p1, p2, p3, p4} codewords.
// It corrects single-bit errors, flags double-bit errors and keeps saturating error counters.
module hamming_sec_ded_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      code_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [10:0]      data_out,
  output logic             err_single,
  output logic             err_double,
  output logic [3:0]       err_pos,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] single_cnt,
  output logic [CNT_W-1:0] double_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [3:0] calc_syndrome(input logic [15:0] cw);
    logic [10:0] d;
    logic [3:0]  syn;
    d      = cw[15:5];
    syn[0] = cw[3] ^ d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10];
    syn[1] = cw[2] ^ d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10];
    syn[2] = cw[1] ^ d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
    syn[3] = cw[0] ^ (^d[10:4]);
    return syn;
  endfunction

  function automatic logic calc_overall(input logic [15:0] cw);
    return ^cw;
  endfunction

  // Maps a Hamming position to the data bit it carries; parity positions map to no data bit.
  function automatic logic [10:0] flip_mask(input logic [3:0] syn);
    logic [10:0] m;
    case (syn)
      4'd3:    m = 11'b000_0000_0001;
      4'd5:    m = 11'b000_0000_0010;
      4'd6:    m = 11'b000_0000_0100;
      4'd7:    m = 11'b000_0000_1000;
      4'd9:    m = 11'b000_0001_0000;
      4'd10:   m = 11'b000_0010_0000;
      4'd11:   m = 11'b000_0100_0000;
      4'd12:   m = 11'b000_1000_0000;
      4'd13:   m = 11'b001_0000_0000;
      4'd14:   m = 11'b010_0000_0000;
      4'd15:   m = 11'b100_0000_0000;
      default: m = 11'd0;
    endcase
    return m;
  endfunction

  logic             s1_valid_r;
  logic [10:0]      s1_data_r;
  logic [3:0]       s1_syn_r;
  logic             s1_ovr_r;
  logic             s2_valid_r;
  logic [10:0]      s2_data_r;
  logic             s2_single_r;
  logic             s2_double_r;
  logic [3:0]       s2_pos_r;
  logic [CNT_W-1:0] single_cnt_r;
  logic [CNT_W-1:0] double_cnt_r;
  logic             s1_adv_s;
  logic             s2_adv_s;
  logic             out_xfer_s;
  logic [10:0]      dec_data_s;
  logic             dec_single_s;
  logic             dec_double_s;
  logic [3:0]       dec_pos_s;

  assign s2_adv_s   = !s2_valid_r || out_ready;
  assign s1_adv_s   = !s1_valid_r || s2_adv_s;
  assign in_ready   = s1_adv_s;
  assign out_xfer_s = s2_valid_r && out_ready;

  assign out_valid  = s2_valid_r;
  assign data_out   = s2_data_r;
  assign err_single = s2_single_r;
  assign err_double = s2_double_r;
  assign err_pos    = s2_pos_r;
  assign single_cnt = single_cnt_r;
  assign double_cnt = double_cnt_r;

  // Stage 1: capture the raw data bits together with the syndrome and overall parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= 11'd0;
      s1_syn_r   <= 4'd0;
      s1_ovr_r   <= 1'b0;
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_data_r <= code_in[15:5];
        s1_syn_r  <= calc_syndrome(code_in);
        s1_ovr_r  <= calc_overall(code_in);
      end else begin
        s1_data_r <= s1_data_r;
      end
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Classify the stage-1 word; an odd overall parity always means one flipped bit.
  always_comb begin
    dec_data_s   = s1_data_r;
    dec_single_s = 1'b0;
    dec_double_s = 1'b0;
    dec_pos_s    = 4'd0;
    if (s1_ovr_r) begin
      dec_single_s = 1'b1;
      dec_pos_s    = s1_syn_r;
      dec_data_s   = s1_data_r ^ flip_mask(s1_syn_r);
    end else if (s1_syn_r != 4'd0) begin
      dec_double_s = 1'b1;
    end else begin
      dec_single_s = 1'b0;
    end
  end

  // Stage 2: registered outputs, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r  <= 1'b0;
      s2_data_r   <= 11'd0;
      s2_single_r <= 1'b0;
      s2_double_r <= 1'b0;
      s2_pos_r    <= 4'd0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_data_r   <= dec_data_s;
        s2_single_r <= dec_single_s;
        s2_double_r <= dec_double_s;
        s2_pos_r    <= dec_pos_s;
      end else begin
        s2_data_r <= s2_data_r;
      end
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  // Saturating error counters, bumped on delivered words; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      single_cnt_r <= {CNT_W{1'b0}};
      double_cnt_r <= {CNT_W{1'b0}};
    end else if (clr_cnt) begin
      single_cnt_r <= {CNT_W{1'b0}};
      double_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (out_xfer_s && s2_single_r && (single_cnt_r != CNT_MAX)) begin
        single_cnt_r <= single_cnt_r + CNT_ONE;
      end else begin
        single_cnt_r <= single_cnt_r;
      end
      if (out_xfer_s && s2_double_r && (double_cnt_r != CNT_MAX)) begin
        double_cnt_r <= double_cnt_r + CNT_ONE;
      end else begin
        double_cnt_r <= double_cnt_r;
      end
    end
  end

endmodule

// File: doc/hamming_sec_ded_decoder.md
Name: hamming_sec_ded_decoder

Overview:
- Pipelined SEC-DED decoder directly downstream of the 11-bit to 16-bit Hamming encoder.
- Accepts 16-bit codewords over a valid/ready handshake and recomputes the syndrome and overall parity.
- Corrects any single-bit error and flags double-bit errors.
- Emits the 11-bit message plus error status, and keeps saturating single- and double-error counters for the message-system status path.

Parameters:
- CNT_W, 8, width of each error counter; counters saturate at 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  codeword present on code_in.
- in_ready  output  1  decoder can accept a codeword this cycle.
- code_in  input  16  codeword = {d[10:0], p0, p1, p2, p3, p4}. Bits [15:5]=d10..d0, [4]=p0 (overall), [3]=p1, [2]=p2, [1]=p3, [0]=p4.
- out_valid  output  1  decoded word present on outputs.
- out_ready  input  1  consumer accepts decoded word.
- data_out  output  11  corrected message d[10:0].
- err_single  output  1  single-bit error detected and corrected.
- err_double  output  1  uncorrectable double-bit error detected.
- err_pos  output  4  Hamming position of corrected bit (1..15); 0 when p0 was the flipped bit or when there is no single error.
- clr_cnt  input  1  synchronous clear of both counters.
- single_cnt  output  CNT_W  count of delivered words with err_single.
- double_cnt  output  CNT_W  count of delivered words with err_double.

Behaviour:
- Position map:
  - pos1=p1, pos2=p2, pos3=d0, pos4=p3.
  - pos5..7=d1..d3, pos8=p4, pos9..15=d4..d10.
- Syndrome bits:
  - s1 = p1 ^ d0^d1^d3^d4^d6^d8^d10.
  - s2 = p2 ^ d0^d2^d3^d5^d6^d9^d10.
  - s3 = p3 ^ d1^d2^d3^d7^d8^d9^d10.
  - s4 = p4 ^ d4..d10.
  - S = {s4,s3,s2,s1}.
  - Overall check o = XOR of all 16 code_in bits.
- Classification:
  - S=0, o=0: clean; data_out = raw d.
  - S!=0, o=1: single error; invert the bit at position S; if S is a parity position, data is unchanged. err_single=1, err_pos=S.
  - S=0, o=1: p0 error; err_single=1, err_pos=0, data unchanged.
  - S!=0, o=0: double error; err_double=1, err_pos=0, data_out = raw d, uncorrected.
  - err_single and err_double are never both 1.
- Pipeline:
  - Stage 1 registers code_in, S and o.
  - Stage 2 registers the corrected data and status.
  - Latency: word accepted at edge N appears with out_valid at edge N+2 when unstalled.
  - Throughput is 1 word/cycle.
- Handshake:
  - s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv, combinational from state and out_ready.
  - Transfer occurs on in_valid & in_ready and on out_valid & out_ready.
  - While out_valid=1 and out_ready=0, all outputs hold stable.
  - Stage 1 holds its word if stage 2 is stalled.
  - No word is dropped or duplicated.
  - Data is captured only on transfer; code_in is ignored when in_valid=0.
- Counters:
  - Increment on output transfer of a word flagged err_single or err_double, respectively.
  - Saturate at all-ones, no wrap.
  - clr_cnt=1 forces both to 0 and takes priority over a simultaneous increment.
- Reset: asynchronous assertion, synchronous deassertion handled by the system reset synchronizer. Values while reset is active:
  - s1_valid=0, s2_valid=0, out_valid=0.
  - data_out=0, err_single=0, err_double=0, err_pos=0.
  - single_cnt=0, double_cnt=0.
  - in_ready=1.
- Reset mid-operation discards in-flight words; the first post-reset output is the first word accepted after reset.

Test Plan:
- Clean words: code_in=16'h0000 then 16'hFFFF (d=11'h7FF), out_ready=1 -> out_valid 2 cycles after each accept; data_out=000 then 7FF; no error flags; counters 0.
- Single data error: 16'h0020 (d0 flipped, pos3) -> data_out=11'h000, err_single=1, err_pos=3, single_cnt=1.
- p0 error: 16'hFFEF -> data_out=11'h7FF, err_single=1, err_pos=0.
- Double error: 16'h0060 (d0 and d1 flipped, S=6, o=0) -> err_double=1, data_out=11'h003, err_pos=0, double_cnt=1.
- Backpressure: stream 4 words with out_ready=0 for 5 cycles -> in_ready drops after 2 accepted words, outputs stable while stalled. Release out_ready -> all 4 words delivered in order, no loss or duplicate.
- Counter saturation and clear: CNT_W=2, deliver 5 single-error words -> single_cnt=3. Assert clr_cnt in the same cycle as a 6th single-error delivery -> single_cnt=0.
- Async reset: assert rst_n=0 with both stages full -> out_valid and counters 0 immediately; next accepted word emerges 2 cycles after accept.
